// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state encoding and op-byte field positions
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  localparam int OP_LSB    = 0;
  localparam int OP_MSB    = 2;
  localparam int CHAIN_BIT = 3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - byte input stream and result output stream of the sequencer
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       flags;
  logic             err;

  modport master (
    output in_data, in_valid, res_ready,
    input  in_ready, res_data, res_valid, flags, err
  );

  modport slave (
    input  in_data, in_valid, res_ready,
    output in_ready, res_data, res_valid, flags, err
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational eight-operation ALU with carry/borrow output
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD:  begin result = sum[WIDTH-1:0]; carry = sum[WIDTH]; end
      // borrow is reported as carry for subtraction
      OP_SUB:  begin result = a - b;          carry = (a < b);    end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - collects A, B, op bytes, runs alu_core, presents result with flags
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  alu_sequencer_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q, res_data_q;
  logic [2:0]       op_q;
  logic             chain_q;
  logic [7:0]       cnt_q;
  logic [1:0]       flags_q;
  logic             res_valid_q;
  logic             err_q;

  logic             in_ready_c;
  logic             in_xfer, res_xfer, timeout_hit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  assign in_xfer     = bus.in_valid && in_ready_c;
  assign res_xfer    = res_valid_q && bus.res_ready;
  assign timeout_hit = ((state == S_B) || (state == S_OP)) && (cnt_q == TIMEOUT_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_A;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready_c = 1'b0;
    case (state)
      S_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) next_state = S_B;
      end
      S_B: begin
        in_ready_c = 1'b1;
        if (bus.in_valid)      next_state = S_OP;
        else if (timeout_hit)  next_state = S_A;
      end
      S_OP: begin
        in_ready_c = 1'b1;
        if (bus.in_valid)      next_state = S_EXEC;
        else if (timeout_hit)  next_state = S_A;
      end
      S_EXEC: next_state = S_RES;
      S_RES: begin
        if (res_xfer) next_state = chain_q ? S_B : S_A;
      end
      default: next_state = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      chain_q     <= 1'b0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_A: begin
          cnt_q <= '0;
          if (in_xfer) a_q <= bus.in_data;
        end
        S_B, S_OP: begin
          if (in_xfer) begin
            cnt_q <= '0;
            if (state == S_B) begin
              b_q <= bus.in_data;
            end else begin
              op_q    <= bus.in_data[OP_MSB:OP_LSB];
              chain_q <= bus.in_data[CHAIN_BIT];
            end
          end else if (timeout_hit) begin
            // abort: drop partial operands and any pending chain
            cnt_q   <= '0;
            err_q   <= 1'b1;
            chain_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_EXEC: begin
          res_data_q  <= alu_res;
          flags_q     <= {alu_carry, (alu_res == '0)};
          res_valid_q <= 1'b1;
        end
        S_RES: begin
          if (res_xfer) begin
            res_valid_q <= 1'b0;
            chain_q     <= 1'b0;
            if (chain_q) a_q <= res_data_q;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

endmodule
